// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: address width, address type and instruction
// alignment constants used by the fetch-stage target logic.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  // Instruction alignment in bits: 32 without the C extension, 16 with it.
  localparam int IALIGN_32 = 32;
  localparam int IALIGN_16 = 16;

  // An address is misaligned when any byte-offset bit below the alignment
  // granule is set.
  function automatic logic addr_misaligned(input addr_t a, input int ialign);
    logic r_mis;
    r_mis = 1'b0;
    if (ialign == IALIGN_16) begin
      r_mis = a[0];
    end else begin
      r_mis = a[1] | a[0];
    end
    return r_mis;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch/jump target calculation: PC plus sign-extended offset,
// with alignment and address-wrap status.
module pc_target_calc
  import rv32_pkg::*;
#(
  parameter int COMPRESSED = 0
) (
  input  addr_t i_pc,
  input  addr_t i_offset,
  output addr_t o_target,
  output logic  o_misaligned,
  output logic  o_wrap
);

  localparam int IALIGN = (COMPRESSED != 0) ? IALIGN_16 : IALIGN_32;

  logic [XLEN:0] w_sum;
  logic          w_carry;

  // 33-bit unsigned add; the carry together with the offset sign tells
  // whether the target crossed the 0 / 2^32 boundary.
  always_comb begin
    w_sum        = {1'b0, i_pc} + {1'b0, i_offset};
    w_carry      = w_sum[XLEN];
    o_target     = w_sum[XLEN-1:0];
    // Positive offset with carry, or negative offset without carry, wrapped.
    o_wrap       = w_carry ^ i_offset[XLEN-1];
    o_misaligned = addr_misaligned(w_sum[XLEN-1:0], IALIGN);
  end

endmodule

// File: rtl/pc_branch_adder.sv
// Fetch-stage branch/jump target generator. Wraps the combinational target
// calculation with an optional output register so the block can sit inside
// or outside the PC-select timing path.
module pc_branch_adder
  import rv32_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          REGISTERED = 1,
  parameter int          COMPRESSED = 0,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] PC_itself,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic            misaligned,
  output logic            wrap
);

  addr_t w_target;
  logic  w_misaligned;
  logic  w_wrap;

  pc_target_calc #(
    .COMPRESSED (COMPRESSED)
  ) u_calc (
    .i_pc         (PC_itself),
    .i_offset     (branch_offset),
    .o_target     (w_target),
    .o_misaligned (w_misaligned),
    .o_wrap       (w_wrap)
  );

  generate
    if (REGISTERED != 0) begin : g_reg
      addr_t r_pc;
      logic  r_vld;
      logic  r_misaligned;
      logic  r_wrap;

      // Output register: data loads only on accepted input and otherwise
      // holds; valid is a one-cycle pulse per accepted input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld        <= 1'b0;
          r_pc         <= RESET_PC;
          r_misaligned <= 1'b0;
          r_wrap       <= 1'b0;
        end else begin
          r_vld <= in_valid;
          if (in_valid) begin
            r_pc         <= w_target;
            r_misaligned <= w_misaligned;
            r_wrap       <= w_wrap;
          end
        end
      end

      assign pc         = r_pc;
      assign out_valid  = r_vld;
      assign misaligned = r_misaligned;
      assign wrap       = r_wrap;
    end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign pc         = w_target;
      assign out_valid  = in_valid;
      assign misaligned = w_misaligned;
      assign wrap       = w_wrap;
    end
  endgenerate

endmodule

// File: tb/tb_pc_branch_adder.sv
// Directed bench for pc_branch_adder: two registered instances (4-byte and
// 2-byte alignment) checked through an expected-result queue, plus a
// combinational instance checked in the same cycle the inputs are driven.
module tb_pc_branch_adder;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        mis_c0;
    logic        mis_c1;
    logic        wrap;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc_in;
    logic [31:0] off;
    logic [31:0] pc;
    logic        mis_c0;
    logic        mis_c1;
    logic        wrap;
  } row_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] off;

  logic [31:0] pc_c0, pc_c1, pc_cb;
  logic        vld_c0, vld_c1, vld_cb;
  logic        mis_c0, mis_c1, mis_cb;
  logic        wrap_c0, wrap_c1, wrap_cb;

  exp_t exp_q[$];
  exp_t hold;
  int   errors = 0;
  int   checks = 0;

  pc_branch_adder #(.XLEN(32), .REGISTERED(1), .COMPRESSED(0), .RESET_PC(RST_PC)) u_c0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .PC_itself(pc_in),
    .branch_offset(off), .pc(pc_c0), .out_valid(vld_c0),
    .misaligned(mis_c0), .wrap(wrap_c0));

  pc_branch_adder #(.XLEN(32), .REGISTERED(1), .COMPRESSED(1), .RESET_PC(RST_PC)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .PC_itself(pc_in),
    .branch_offset(off), .pc(pc_c1), .out_valid(vld_c1),
    .misaligned(mis_c1), .wrap(wrap_c1));

  pc_branch_adder #(.XLEN(32), .REGISTERED(0), .COMPRESSED(0), .RESET_PC(RST_PC)) u_cb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .PC_itself(pc_in),
    .branch_offset(off), .pc(pc_cb), .out_valid(vld_cb),
    .misaligned(mis_cb), .wrap(wrap_cb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Registered outputs of both instances against one expected entry.
  task automatic chk_reg(input string tag, input exp_t e);
    chk({tag, ".c0.vld"},  {31'd0, vld_c0},  {31'd0, e.vld});
    chk({tag, ".c1.vld"},  {31'd0, vld_c1},  {31'd0, e.vld});
    chk({tag, ".c0.pc"},   pc_c0,            e.pc);
    chk({tag, ".c1.pc"},   pc_c1,            e.pc);
    chk({tag, ".c0.mis"},  {31'd0, mis_c0},  {31'd0, e.mis_c0});
    chk({tag, ".c1.mis"},  {31'd0, mis_c1},  {31'd0, e.mis_c1});
    chk({tag, ".c0.wrap"}, {31'd0, wrap_c0}, {31'd0, e.wrap});
    chk({tag, ".c1.wrap"}, {31'd0, wrap_c1}, {31'd0, e.wrap});
  endtask

  // One clock cycle: drive at the falling edge, push the expectation, check
  // the combinational instance, then pop and check just after the rising edge.
  task automatic step(input string tag, input logic v, input row_t r);
    exp_t e;
    exp_t got;
    @(negedge clk);
    in_valid = v;
    pc_in    = r.pc_in;
    off      = r.off;
    if (v) begin
      hold.pc     = r.pc;
      hold.mis_c0 = r.mis_c0;
      hold.mis_c1 = r.mis_c1;
      hold.wrap   = r.wrap;
    end
    e     = hold;
    e.vld = v;
    exp_q.push_back(e);
    #1;
    chk({tag, ".cb.vld"}, {31'd0, vld_cb}, {31'd0, v});
    if (v) begin
      chk({tag, ".cb.pc"},   pc_cb,            r.pc);
      chk({tag, ".cb.mis"},  {31'd0, mis_cb},  {31'd0, r.mis_c0});
      chk({tag, ".cb.wrap"}, {31'd0, wrap_cb}, {31'd0, r.wrap});
    end
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk_reg(tag, got);
    end
  endtask

  row_t rows[11];

  initial begin
    //            pc_in          offset         pc             m0    m1    wrap
    rows[0]  = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    rows[1]  = '{32'h0000_0010, 32'h0000_0008, 32'h0000_0018, 1'b0, 1'b0, 1'b0};
    rows[2]  = '{32'h0000_FF00, 32'hFFFF_FFFC, 32'h0000_FEFC, 1'b0, 1'b0, 1'b0};
    rows[3]  = '{32'h0000_FFFF, 32'h0000_0010, 32'h0001_000F, 1'b1, 1'b1, 1'b0};
    rows[4]  = '{32'hFFFF_FF00, 32'h0000_0004, 32'hFFFF_FF04, 1'b0, 1'b0, 1'b0};
    rows[5]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    rows[6]  = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004, 1'b0, 1'b0, 1'b1};
    rows[7]  = '{32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1};
    rows[8]  = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    rows[9]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    rows[10] = '{32'h0000_1001, 32'hFFFF_FFFE, 32'h0000_0FFF, 1'b1, 1'b1, 1'b0};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    pc_in    = 32'h0;
    off      = 32'h0;
    hold     = '{1'b0, RST_PC, 1'b0, 1'b0, 1'b0};

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk_reg("por", hold);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back table stream
    for (int i = 0; i < 11; i++) begin
      step($sformatf("row%0d", i), 1'b1, rows[i]);
    end

    // Reset asserted between edges mid-stream; input in that cycle is dropped
    @(negedge clk);
    in_valid = 1'b1;
    pc_in    = rows[3].pc_in;
    off      = rows[3].off;
    #2 rst_n = 1'b0;
    #1;
    hold = '{1'b0, RST_PC, 1'b0, 1'b0, 1'b0};
    chk_reg("rst_async", hold);
    @(posedge clk);
    #1;
    chk_reg("rst_edge", hold);
    @(negedge clk);
    rst_n = 1'b1;

    // Resume: first capture after release, then a one-cycle bubble
    step("post_rst0", 1'b1, rows[6]);
    step("post_rst1", 1'b1, rows[8]);
    step("bubble",    1'b0, rows[1]);
    step("resume",    1'b1, rows[7]);
    step("idle",      1'b0, rows[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_branch_adder.md
# pc_branch_adder

Branch/jump target generator for the RV32 core's fetch stage. Adds the current PC to a sign-extended immediate offset and produces the redirect target plus alignment and address-wrap status. The result goes to the PC-select mux; the status goes to the trap logic. An optional output register lets the block sit inside or outside the PC-select timing path.

## Interface
Parameters:
- `XLEN`, 32: address/data width. Only 32 is supported.
- `REGISTERED`, 1: 1 = outputs registered, one-cycle latency; 0 = outputs purely combinational.
- `COMPRESSED`, 0: 1 = C extension present, 2-byte target alignment; 0 = 4-byte alignment.
- `RESET_PC`, 32'h0000_0000: reset value of `pc` when `REGISTERED=1`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: operands valid this cycle.
- `PC_itself`, input, 32: current PC, unsigned byte address.
- `branch_offset`, input, 32: already sign-extended two's-complement byte offset.
- `pc`, output, 32: target = `PC_itself + branch_offset` mod 2^32.
- `out_valid`, output, 1: `pc` and the flags are valid.
- `misaligned`, output, 1: target violates the instruction-alignment rule.
- `wrap`, output, 1: target crossed the 0 / 2^32 address boundary.

## Operation
- Sum is a 33-bit unsigned add of `PC_itself` and `branch_offset`. `pc` = sum[31:0]; carry = sum[32].
- `wrap` = carry XOR `branch_offset[31]`:
  - A positive offset that carries out is a wrap.
  - A negative offset with no carry (target went below 0) is a wrap.
  - An offset of 0 never wraps.
- `misaligned`:
  - `COMPRESSED=0`: `pc[1]` OR `pc[0]`.
  - `COMPRESSED=1`: `pc[0]` only.
- Flags are informational only. `pc` is always the wrapped sum and is never suppressed or saturated.
- No internal state beyond the optional output register. No FSM.

## Timing
- `REGISTERED=1`:
  - On each rising `clk` with `in_valid=1`, capture `pc`, `misaligned` and `wrap`, and set `out_valid=1` next cycle.
  - With `in_valid=0`, data registers hold their previous value and `out_valid` is 0 next cycle. `out_valid` pulses once per accepted input.
  - Back-to-back `in_valid` gives one result per cycle with no bubbles.
- `REGISTERED=0`:
  - Outputs are a combinational function of the inputs.
  - `out_valid` = `in_valid`.
  - `clk`/`rst_n` are unused.
- Reset (`rst_n` low, asynchronous, any time including mid-stream):
  - `pc` = `RESET_PC`; `out_valid`, `misaligned`, `wrap` = 0.
  - An input presented during the reset cycle is discarded.
  - First capture happens on the first rising edge after `rst_n` deasserts.
- There is no backpressure. The consumer must accept `out_valid` in the cycle it is asserted.

## Structure
- Shared package `rv32_pkg`: `XLEN` constant, `addr_t` typedef (logic [31:0]), `IALIGN_32`/`IALIGN_16` constants.
- One sub-module, `pc_target_calc`: purely combinational; produces sum, `misaligned` and `wrap`.
- The top level wraps `pc_target_calc` with the `REGISTERED` generate branch and the reset logic.

## Test plan
Each row: `PC_itself` + `branch_offset` → expected `pc`, `misaligned`, `wrap`. Bench checks all rows with `REGISTERED=1` and `in_valid=1` every cycle.
- Basic adds:
  - `0x00000000` + `0x00000004` → `0x00000004`, mis 0, wrap 0.
  - `0x00000010` + `0x00000008` → `0x00000018`, mis 0, wrap 0.
- Negative offset, no wrap: `0x0000FF00` + `0xFFFFFFFC` → `0x0000FEFC`, mis 0, wrap 0. Also check result appears exactly one cycle after capture.
- Misaligned and high-address cases:
  - `0x0000FFFF` + `0x00000010` → `0x0001000F`, mis 1 for both `COMPRESSED` values.
  - `0xFFFFFF00` + `0x00000004` → `0xFFFFFF04`, wrap 0.
  - `0x00000000` + `0x00000000` → `0x00000000`, all flags 0.
- Wrap cases:
  - `0xFFFFFFFC` + `0x00000008` → `0x00000004`, wrap 1.
  - `0x00000000` + `0xFFFFFFFC` → `0xFFFFFFFC`, wrap 1.
  - `0x00000002` + `0x00000000` with `COMPRESSED=1` → mis 0; same stimulus with `COMPRESSED=0` → mis 1.
- Reset mid-stream: assert `rst_n` low between clock edges during a back-to-back stream.
  - Outputs go immediately to `RESET_PC`/0 with no clock edge needed.
  - After release, the next accepted input appears one cycle later.
  - Dropping `in_valid` for one cycle deasserts `out_valid` for one cycle while `pc` holds its last value.
